// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks EX/MEM/WB destination registers, drives the
// ALU operand forwarding selects and raises a one-cycle load-use stall.
// Honours branch flush (bubble into EX) and freeze (hold everything).
// Optional feature macro: HAZARD_STATS_EN enables the load-use stall counter;
// without it stall_count is tied to zero.
module hazard_forward_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             freeze,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } slot_t;

  slot_t            ex_q;
  slot_t            mem_q;
  slot_t            wb_q;
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  state_t           state;
  logic             load_use;

  // MEM beats WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input slot_t mem_s,
                                         input slot_t wb_s);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_s.valid && mem_s.reg_write && (mem_s.rd != '0) && (mem_s.rd == rs))
      sel = 2'b10;
    else if (wb_s.valid && wb_s.reg_write && (wb_s.rd != '0) && (wb_s.rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // Forwarding selects and load-use stall, all combinational from the slots.
  always_comb begin
    forward_a = fwd_sel(ex_rs1, mem_q, wb_q);
    forward_b = fwd_sel(ex_rs2, mem_q, wb_q);
    load_use  = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    // BUBBLE masks the re-presented consumer whose hazard is already resolved.
    stall     = load_use && (state == RUN) && !freeze && !flush;
  end

  // Pipeline slot advance and RUN/BUBBLE state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      state  <= RUN;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q   <= '0;
        ex_rs1 <= '0;
        ex_rs2 <= '0;
      end else begin
        ex_q.valid     <= id_valid;
        ex_q.rd        <= id_rd;
        ex_q.reg_write <= id_reg_write;
        ex_q.mem_read  <= id_mem_read;
        ex_rs1         <= id_rs1;
        ex_rs2         <= id_rs2;
      end
      // stall is already forced low under flush, so flush+hazard stays in RUN.
      case (state)
        RUN:     state <= stall ? BUBBLE : RUN;
        BUBBLE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Count unfrozen load-use stall cycles; wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if (stall)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios followed by
// randomized traffic, compared against a pipeline reference model.
module tb_hazard_forward_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             freeze;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  hazard_forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .freeze       (freeze),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per stage, plus a "bubble cycle" flag.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    int rs1;
    int rs2;
  } ent_t;

  ent_t             m_ex, m_mem, m_wb;
  bit               m_bub;
  logic [CNT_W-1:0] m_cnt;
  bit               known = 0;

  logic [31:0] obs_fa, obs_fb, obs_st, obs_cnt;

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 0; e.rd = 0; e.rw = 0; e.mr = 0; e.rs1 = 0; e.rs2 = 0;
    return e;
  endfunction

  function automatic int m_fwd(int rs);
    if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2;
    if (m_wb.v && m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit hit;
    hit = m_ex.v && m_ex.mr && m_ex.rd != 0 && id_valid &&
          (m_ex.rd == int'(id_rs1) || m_ex.rd == int'(id_rs2));
    return hit && !m_bub && !freeze && !flush;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample/check at negedge, advance the model, then return 1ns
  // after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    bit   s;
    ent_t n;
    @(negedge clk);
    obs_fa  = 32'(forward_a);
    obs_fb  = 32'(forward_b);
    obs_st  = 32'(stall);
    obs_cnt = 32'(stall_count);
    s = m_stall();
    if (known) begin
      chk("forward_a", obs_fa, 32'(m_fwd(int'(m_ex.rs1))));
      chk("forward_b", obs_fb, 32'(m_fwd(int'(m_ex.rs2))));
      chk("stall", obs_st, 32'(s));
`ifdef HAZARD_STATS_EN
      chk("stall_count", obs_cnt, 32'(m_cnt));
`else
      chk("stall_count", obs_cnt, 32'd0);
`endif
    end
    if (!reset) begin
      m_ex = empty_ent(); m_mem = empty_ent(); m_wb = empty_ent();
      m_bub = 0; m_cnt = '0;
    end else if (!freeze) begin
      if (s) m_cnt = m_cnt + CNT_W'(1);
      m_wb  = m_mem;
      m_mem = m_ex;
      if (flush || s) m_ex = empty_ent();
      else begin
        n.v = id_valid; n.rd = int'(id_rd); n.rw = id_reg_write;
        n.mr = id_mem_read; n.rs1 = int'(id_rs1); n.rs2 = int'(id_rs2);
        m_ex = n;
      end
      m_bub = s;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rd, input int rs1, input int rs2,
                        input bit rw, input bit mr);
    id_valid = v; id_rd = REG_W'(rd); id_rs1 = REG_W'(rs1); id_rs2 = REG_W'(rs2);
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop(); flush = 0; freeze = 0;
    repeat (3) cycle();
  endtask

  task automatic set_rand();
    set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    flush  = ($urandom_range(0, 7) == 0);
    freeze = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    m_ex = empty_ent(); m_mem = empty_ent(); m_wb = empty_ent();
    m_bub = 0; m_cnt = '0;

    // Reset held low two cycles with random inputs.
    reset = 0;
    set_rand();
    cycle();
    known = 1;
    set_rand();
    cycle();
    chk("rst_fa", obs_fa, 0); chk("rst_fb", obs_fb, 0);
    chk("rst_stall", obs_st, 0); chk("rst_cnt", obs_cnt, 0);
    reset = 1; flush = 0; freeze = 0; nop();
    cycle();
    chk("post_rst_fa", obs_fa, 0); chk("post_rst_stall", obs_st, 0);

    // EX->EX: add x5 then add x6,x5,x5.
    set_id(1, 5, 1, 2, 1, 0); cycle();
    set_id(1, 6, 5, 5, 1, 0); cycle();
    nop(); cycle();
    chk("exex_fa", obs_fa, 2); chk("exex_fb", obs_fb, 2);
    drain();

    // Double hit on x7: MEM must win.
    set_id(1, 7, 1, 2, 1, 0); cycle();
    set_id(1, 7, 3, 4, 1, 0); cycle();
    set_id(1, 10, 7, 3, 1, 0); cycle();
    nop(); cycle();
    chk("dbl_fa", obs_fa, 2); chk("dbl_fb", obs_fb, 0);
    drain();

    // Load-use: lw x8 then add x9,x8,x1.
    set_id(1, 8, 2, 0, 1, 1); cycle();
    set_id(1, 9, 8, 1, 1, 0); cycle();
    chk("lu_stall_n", obs_st, 1);
    cycle();
    chk("lu_stall_n1", obs_st, 0);
    nop(); cycle();
    chk("lu_fa", obs_fa, 1); chk("lu_fb", obs_fb, 0); chk("lu_stall_n2", obs_st, 0);
`ifdef HAZARD_STATS_EN
    chk("lu_cnt", obs_cnt, 1);
`else
    chk("lu_cnt", obs_cnt, 0);
`endif
    drain();

    // x0 write then x0 read: no forwarding.
    set_id(1, 0, 1, 2, 1, 0); cycle();
    set_id(1, 11, 0, 0, 1, 0); cycle();
    nop(); cycle();
    chk("x0_fa", obs_fa, 0); chk("x0_fb", obs_fb, 0);
    // lw x0 followed by x0 reader: no stall.
    set_id(1, 0, 1, 2, 1, 1); cycle();
    set_id(1, 12, 0, 0, 1, 0); cycle();
    chk("x0_lw_stall", obs_st, 0);
    drain();

    // Flush in the cycle after lw kills the dependent: no stall.
    set_id(1, 8, 2, 0, 1, 1); cycle();
    set_id(1, 9, 8, 8, 1, 0); flush = 1; cycle();
    chk("flush_stall", obs_st, 0);
    flush = 0; nop(); cycle();
    chk("flush_stall_after", obs_st, 0);
    drain();

    // Freeze for three cycles during BUBBLE.
    set_id(1, 8, 2, 0, 1, 1); cycle();
    set_id(1, 9, 8, 1, 1, 0); cycle();
    chk("frz_stall_n", obs_st, 1);
    freeze = 1;
    repeat (3) begin
      cycle();
      chk("frz_stall", obs_st, 0); chk("frz_fa", obs_fa, 0);
    end
    freeze = 0;
    cycle();
    chk("frz_rel_stall", obs_st, 0);
    nop(); cycle();
    chk("frz_rel_fa", obs_fa, 1); chk("frz_rel_fb", obs_fb, 0);
    drain();

    // Randomized traffic with occasional flush, freeze and reset.
    for (int i = 0; i < 400; i++) begin
      set_rand();
      reset = ($urandom_range(0, 63) != 0);
      cycle();
    end
    reset = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
